// File: rtl/logs_tone_gen.sv
// logs_tone_gen: square-wave tone generator with a one-entry note queue.
// Notes (half-period, duration, sweep) are accepted into a pending slot
// and played back-to-back without gaps. A half-period of 0 plays a rest.
// Optional feature macro: LOGS_TONE_SWEEP_EN (per-tick half-period sweep).
module logs_tone_gen #(
    parameter int PW       = 12,
    parameter int DW       = 8,
    parameter int PRESCALE = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          note_valid,
    output logic          note_ready,
    input  logic [PW-1:0] note_period,
    input  logic [DW-1:0] note_dur,
    input  logic [3:0]    note_sweep,
    output logic          audio_out,
    output logic          active
);

    localparam int SW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [SW-1:0] PRESC_LAST = SW'(PRESCALE - 1);

    typedef enum logic {IDLE, PLAY} state_e;

    state_e state_q, state_d;

    logic          pendFull_q,   pendFull_d;
    logic [PW-1:0] pendPeriod_q, pendPeriod_d;
    logic [DW-1:0] pendDur_q,    pendDur_d;
    logic [3:0]    pendSweep_q,  pendSweep_d;

    logic [PW-1:0] curPeriod_q,  curPeriod_d;
    logic [DW-1:0] remDur_q,     remDur_d;
    logic [PW-1:0] phase_q,      phase_d;
    logic [SW-1:0] presc_q,      presc_d;
    logic          audio_q,      audio_d;

    logic accept;
    logic tick;
    logic lastTick;
    logic loadCur;

`ifdef LOGS_TONE_SWEEP_EN
    localparam logic signed [PW+1:0] SUM_ONE = {{(PW+1){1'b0}}, 1'b1};
    localparam logic signed [PW+1:0] SUM_MAX = {2'b00, {PW{1'b1}}};

    logic [3:0]           curSweep_q, curSweep_d;
    logic signed [PW+1:0] sweepSum;
    logic [PW-1:0]        sweptPeriod;

    // Next swept half-period, clamped so a tone never degrades into a rest.
    always_comb begin
        sweepSum = $signed({2'b00, curPeriod_q}) + (PW+2)'($signed(curSweep_q));
        if (sweepSum < SUM_ONE) begin
            sweptPeriod = {{(PW-1){1'b0}}, 1'b1};
        end else if (sweepSum > SUM_MAX) begin
            sweptPeriod = {PW{1'b1}};
        end else begin
            sweptPeriod = sweepSum[PW-1:0];
        end
    end
`else
    logic unusedSweep;
    assign unusedSweep = ^pendSweep_q;
`endif

    // Handshake and timing strobes shared by the FSM and the datapath.
    always_comb begin
        accept   = note_valid && !pendFull_q;
        tick     = (state_q == PLAY) && (presc_q == PRESC_LAST);
        lastTick = tick && (remDur_q <= DW'(1));
        loadCur  = pendFull_q && ((state_q == IDLE) || lastTick);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: start when a note is pending, stop when the last note ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pendFull_q) state_d = PLAY;
            PLAY:    if (lastTick && !pendFull_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready follows the pending slot, active follows PLAY.
    always_comb begin
        note_ready = !pendFull_q;
        audio_out  = audio_q;
        active     = (state_q == PLAY);
    end

    // Datapath next state: pending slot, note load, prescaler, phase and tone.
    always_comb begin
        pendFull_d   = pendFull_q;
        pendPeriod_d = pendPeriod_q;
        pendDur_d    = pendDur_q;
        pendSweep_d  = pendSweep_q;
        curPeriod_d  = curPeriod_q;
        remDur_d     = remDur_q;
        phase_d      = phase_q;
        presc_d      = presc_q;
        audio_d      = audio_q;
`ifdef LOGS_TONE_SWEEP_EN
        curSweep_d   = curSweep_q;
`endif
        if (loadCur) begin
            pendFull_d  = 1'b0;
            curPeriod_d = pendPeriod_q;
            remDur_d    = (pendDur_q == '0) ? DW'(1) : pendDur_q;
            phase_d     = '0;
            presc_d     = '0;
            audio_d     = 1'b0;
`ifdef LOGS_TONE_SWEEP_EN
            curSweep_d  = pendSweep_q;
`endif
        end else if (state_q == PLAY) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick) begin
                remDur_d = remDur_q - 1'b1;
            end
            if (lastTick || (curPeriod_q == '0)) begin
                phase_d = '0;
                audio_d = 1'b0;
            end else if (phase_q >= curPeriod_q - 1'b1) begin
                phase_d = '0;
                audio_d = !audio_q;
            end else begin
                phase_d = phase_q + 1'b1;
            end
`ifdef LOGS_TONE_SWEEP_EN
            if (tick && !lastTick && (curPeriod_q != '0)) begin
                curPeriod_d = sweptPeriod;
            end
`endif
        end
        if (accept) begin
            pendFull_d   = 1'b1;
            pendPeriod_d = note_period;
            pendDur_d    = note_dur;
            pendSweep_d  = note_sweep;
        end
    end

    // Datapath registers; reset discards both the playing and pending note.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pendFull_q   <= 1'b0;
            pendPeriod_q <= '0;
            pendDur_q    <= '0;
            pendSweep_q  <= '0;
            curPeriod_q  <= '0;
            remDur_q     <= '0;
            phase_q      <= '0;
            presc_q      <= '0;
            audio_q      <= 1'b0;
`ifdef LOGS_TONE_SWEEP_EN
            curSweep_q   <= '0;
`endif
        end else begin
            pendFull_q   <= pendFull_d;
            pendPeriod_q <= pendPeriod_d;
            pendDur_q    <= pendDur_d;
            pendSweep_q  <= pendSweep_d;
            curPeriod_q  <= curPeriod_d;
            remDur_q     <= remDur_d;
            phase_q      <= phase_d;
            presc_q      <= presc_d;
            audio_q      <= audio_d;
`ifdef LOGS_TONE_SWEEP_EN
            curSweep_q   <= curSweep_d;
`endif
        end
    end

endmodule

// File: tb/tb_logs_tone_gen.sv
// tb_logs_tone_gen: directed test of logs_tone_gen with PRESCALE=4.
// Expected tone patterns are hand-derived bit vectors, one bit per cycle.
module tb_logs_tone_gen;

    logic        clk;
    logic        rst;
    logic        note_valid;
    logic        note_ready;
    logic [11:0] note_period;
    logic [7:0]  note_dur;
    logic [3:0]  note_sweep;
    logic        audio_out;
    logic        active;

    int checks;
    int failures;

    logic [7:0]  expAudioA;
    logic [7:0]  expAudioB;
    logic [7:0]  expReadyB;
    logic [15:0] expAudioS;

    logs_tone_gen #(
        .PW(12),
        .DW(8),
        .PRESCALE(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .note_valid(note_valid),
        .note_ready(note_ready),
        .note_period(note_period),
        .note_dur(note_dur),
        .note_sweep(note_sweep),
        .audio_out(audio_out),
        .active(active)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [11:0] p, input logic [7:0] d,
                                 input logic [3:0] s);
        note_valid  = v;
        note_period = p;
        note_dur    = d;
        note_sweep  = s;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Directed scenarios, each starting and ending with the block idle.
    initial begin
        checks    = 0;
        failures  = 0;
        expAudioA = 8'b0011_1000;
        expAudioB = 8'b0000_1100;
        expReadyB = 8'b1111_0001;
`ifdef LOGS_TONE_SWEEP_EN
        expAudioS = 16'hAAAC;
`else
        expAudioS = 16'hCCCC;
`endif
        rst = 1'b1;
        applyStimulus(1'b0, 12'd0, 8'd0, 4'd0);
        #1;
        checkOutput("rst_audio", audio_out, 1'b0);
        checkOutput("rst_active", active, 1'b0);
        checkOutput("rst_ready", note_ready, 1'b1);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();

        $display("[TB] scenario A: period 3, dur 2");
        applyStimulus(1'b1, 12'd3, 8'd2, 4'd0);
        stepCycle();
        checkOutput("A_ready_after_accept", note_ready, 1'b0);
        checkOutput("A_active_not_yet", active, 1'b0);
        applyStimulus(1'b0, 12'd0, 8'd0, 4'd0);
        stepCycle();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) stepCycle();
            checkOutput("A_audio", audio_out, expAudioA[i]);
            checkOutput("A_active", active, 1'b1);
        end
        stepCycle();
        checkOutput("A_active_end", active, 1'b0);
        checkOutput("A_audio_end", audio_out, 1'b0);
        stepCycle();

        $display("[TB] scenario B: back-to-back notes");
        applyStimulus(1'b1, 12'd2, 8'd1, 4'd0);
        stepCycle();
        checkOutput("B_ready_full", note_ready, 1'b0);
        applyStimulus(1'b1, 12'd5, 8'd1, 4'd0);
        stepCycle();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) stepCycle();
            checkOutput("B_audio", audio_out, expAudioB[i]);
            checkOutput("B_active", active, 1'b1);
            checkOutput("B_ready", note_ready, expReadyB[i]);
            if (i == 1) applyStimulus(1'b0, 12'd0, 8'd0, 4'd0);
        end
        stepCycle();
        checkOutput("B_active_end", active, 1'b0);
        stepCycle();

        $display("[TB] scenario C: rest, dur 3");
        applyStimulus(1'b1, 12'd0, 8'd3, 4'd0);
        stepCycle();
        applyStimulus(1'b0, 12'd0, 8'd0, 4'd0);
        stepCycle();
        for (int i = 0; i < 12; i++) begin
            if (i > 0) stepCycle();
            checkOutput("C_audio", audio_out, 1'b0);
            checkOutput("C_active", active, 1'b1);
        end
        stepCycle();
        checkOutput("C_active_end", active, 1'b0);
        stepCycle();

        $display("[TB] scenario D: dur 0 plays one tick");
        applyStimulus(1'b1, 12'd4, 8'd0, 4'd0);
        stepCycle();
        applyStimulus(1'b0, 12'd0, 8'd0, 4'd0);
        stepCycle();
        for (int i = 0; i < 4; i++) begin
            if (i > 0) stepCycle();
            checkOutput("D_active", active, 1'b1);
            checkOutput("D_audio", audio_out, 1'b0);
        end
        stepCycle();
        checkOutput("D_active_end", active, 1'b0);
        stepCycle();

        $display("[TB] scenario S: period 2, sweep -1, dur 4");
        applyStimulus(1'b1, 12'd2, 8'd4, 4'hF);
        stepCycle();
        applyStimulus(1'b0, 12'd0, 8'd0, 4'd0);
        stepCycle();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) stepCycle();
            checkOutput("S_audio", audio_out, expAudioS[i]);
            checkOutput("S_active", active, 1'b1);
        end
        stepCycle();
        checkOutput("S_active_end", active, 1'b0);
        stepCycle();

        $display("[TB] scenario R: reset mid-note with pending full");
        applyStimulus(1'b1, 12'd3, 8'd2, 4'd0);
        stepCycle();
        applyStimulus(1'b1, 12'd4, 8'd2, 4'd0);
        stepCycle();
        stepCycle();
        applyStimulus(1'b0, 12'd0, 8'd0, 4'd0);
        stepCycle();
        stepCycle();
        checkOutput("R_pre_audio", audio_out, 1'b1);
        checkOutput("R_pre_ready", note_ready, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("R_audio", audio_out, 1'b0);
        checkOutput("R_active", active, 1'b0);
        checkOutput("R_ready", note_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            checkOutput("R_no_stale_active", active, 1'b0);
            checkOutput("R_no_stale_audio", audio_out, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
